// File: rtl/charbuf_arb.sv
// Character-buffer RAM arbiter: one single-port RAM shared by the display
// fetch path, a full-buffer clear sequencer and two round-robin writers.
// Every request sampled at an edge becomes a registered RAM command in the
// following cycle; display reads always win, then the clear, then writers.
module charbuf_arb #(
    parameter int         DEPTH    = 4800,
    parameter int         AW       = 13,
    parameter logic [7:0] CLR_CHAR = 8'h20
) (
    input  logic          px_clk,
    input  logic          rst,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          rd_valid,
    input  logic          wr0_req,
    input  logic [AW-1:0] wr0_addr,
    input  logic [7:0]    wr0_data,
    output logic          wr0_ack,
    input  logic          wr1_req,
    input  logic [AW-1:0] wr1_addr,
    input  logic [7:0]    wr1_data,
    output logic          wr1_ack,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata
);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            prio_q, prio_d;     // 1: writer 1 wins a tie
    logic            ack0_q, ack0_d;
    logic            ack1_q, ack1_d;
    logic            rd_valid_q, rd_valid_d;
    logic            ram_en_q, ram_en_d;
    logic            ram_we_q, ram_we_d;
    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic [7:0]      ram_wdata_q, ram_wdata_d;

    logic            elig0, elig1, pick1;

    // A writer acked in this cycle is still holding its request; skip it once.
    assign elig0 = wr0_req & ~ack0_q;
    assign elig1 = wr1_req & ~ack1_q;
    assign pick1 = elig1 & (~elig0 | prio_q);

    // Arbitration and next-state for the clear FSM and the registered command.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        prio_d      = prio_q;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        ram_en_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        // Read data comes back one cycle after a read command was on the bus.
        rd_valid_d  = ram_en_q & ~ram_we_q;

        if (rd_req) begin
            ram_en_d   = 1'b1;
            ram_addr_d = rd_addr;
        end else if (state_q == CLEAR) begin
            ram_en_d    = 1'b1;
            ram_we_d    = 1'b1;
            ram_addr_d  = cnt_q;
            ram_wdata_d = CLR_CHAR;
            if (cnt_q == AW'(DEPTH - 1)) begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end else begin
                cnt_d = cnt_q + AW'(1);
            end
        end else if (!clr_start && (elig0 || elig1)) begin
            // The start edge of a clear grants nobody: its ack would land in a busy cycle.
            if (pick1) begin
                ack1_d = 1'b1;
                prio_d = 1'b0;
                if (32'(wr1_addr) < DEPTH) begin
                    ram_en_d    = 1'b1;
                    ram_we_d    = 1'b1;
                    ram_addr_d  = wr1_addr;
                    ram_wdata_d = wr1_data;
                end
            end else begin
                ack0_d = 1'b1;
                prio_d = 1'b1;
                if (32'(wr0_addr) < DEPTH) begin
                    ram_en_d    = 1'b1;
                    ram_we_d    = 1'b1;
                    ram_addr_d  = wr0_addr;
                    ram_wdata_d = wr0_data;
                end
            end
        end

        // A clear start is taken only from IDLE; a read on the same edge does not delay it.
        if (state_q == IDLE && clr_start) begin
            state_d = CLEAR;
            cnt_d   = '0;
            busy_d  = 1'b1;
        end
    end

    // All state and outputs registered; reset aborts any clear in progress.
    always_ff @(posedge px_clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            prio_q      <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            prio_q      <= prio_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            rd_valid_q  <= rd_valid_d;
            ram_en_q    <= ram_en_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign clr_busy  = busy_q;
    assign wr0_ack   = ack0_q;
    assign wr1_ack   = ack1_q;
    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_valid_q ? ram_rdata : 8'h00;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_charbuf_arb.sv
// Directed bench for charbuf_arb: per-cycle vector table for arbitration,
// plus hand-written sequences for display priority, clears and reset.
module tb_charbuf_arb;
    localparam int AW    = 13;
    localparam int DEPTH = 4800;

    logic          px_clk = 1'b0;
    logic          rst = 1'b0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic [7:0]    rd_data;
    logic          rd_valid;
    logic          wr0_req = 1'b0, wr1_req = 1'b0;
    logic [AW-1:0] wr0_addr = '0, wr1_addr = '0;
    logic [7:0]    wr0_data = '0, wr1_data = '0;
    logic          wr0_ack, wr1_ack;
    logic          clr_start = 1'b0;
    logic          clr_busy;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata = '0;

    int errors = 0;
    int checks = 0;

    charbuf_arb #(.DEPTH(DEPTH), .AW(AW), .CLR_CHAR(8'h20)) dut (
        .px_clk(px_clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_ack(wr0_ack),
        .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ack(wr1_ack),
        .clr_start(clr_start), .clr_busy(clr_busy),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 px_clk = ~px_clk;

    // Synchronous single-port RAM model.
    logic [7:0] mem [0:8191];
    always @(posedge px_clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic rd; logic [12:0] ra;
        logic w0; logic [12:0] a0; logic [7:0] d0;
        logic w1; logic [12:0] a1; logic [7:0] d1;
        logic en; logic we; logic [12:0] ea; logic [7:0] ed;
        logic k0; logic k1; logic rv; logic [7:0] rdat;
    } vec_t;

    vec_t tbl [14];

    // Runs one clear; alt=1 puts a read on every other edge. Writer 0 may be held meanwhile.
    task automatic do_clear(input bit alt, input int exp_busy, input string tag);
        int nw, nb, bad, acks;
        nw = 0; nb = 0; bad = 0; acks = 0;
        @(negedge px_clk); clr_start = 1'b1;
        @(posedge px_clk); #1;
        chk({tag, "_busy_rise"}, clr_busy, 1);
        chk({tag, "_start_no_cmd"}, ram_en, 0);
        nb = 1;
        for (int i = 0; i < 12000; i++) begin
            @(negedge px_clk);
            clr_start = (i == 100);
            rd_req    = alt && (i % 2 == 0);
            rd_addr   = 13'd100;
            @(posedge px_clk); #1;
            if (ram_en && ram_we) begin
                if (ram_addr != AW'(nw) || ram_wdata != 8'h20) bad++;
                nw++;
            end
            if (wr0_ack) acks++;
            if (!clr_busy) break;
            nb++;
        end
        rd_req = 1'b0;
        chk({tag, "_writes"}, nw, DEPTH);
        chk({tag, "_busy_cycles"}, nb, exp_busy);
        chk({tag, "_addr_order"}, bad, 0);
        chk({tag, "_no_wr_ack"}, acks, 0);
    endtask

    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 8'h00;
        mem[100] = 8'h41;

        // Reset is asynchronous: outputs clear without a clock edge.
        #2 rst = 1'b1;
        #1;
        chk("reset_outputs",
            {ram_en, ram_we, ram_addr, ram_wdata, wr0_ack, wr1_ack, rd_valid, rd_data, clr_busy},
            '0);
        @(negedge px_clk); rst = 1'b0;

        //          rd  ra    w0 a0   d0     w1 a1    d1     en we ea   ed     k0 k1 rv rdat
        tbl[0]  = '{0, 0,    0, 0,  8'h00, 0, 0,    8'h00, 0, 0, 0,   8'h00, 0, 0, 0, 8'h00};
        tbl[1]  = '{0, 0,    1, 10, 8'h55, 0, 0,    8'h00, 1, 1, 10,  8'h55, 1, 0, 0, 8'h00};
        tbl[2]  = '{0, 0,    1, 10, 8'h55, 0, 0,    8'h00, 0, 0, 0,   8'h00, 0, 0, 0, 8'h00};
        tbl[3]  = '{0, 0,    0, 0,  8'h00, 1, 20,   8'h66, 1, 1, 20,  8'h66, 0, 1, 0, 8'h00};
        tbl[4]  = '{0, 0,    1, 30, 8'h77, 1, 40,   8'h88, 1, 1, 30,  8'h77, 1, 0, 0, 8'h00};
        tbl[5]  = '{0, 0,    1, 30, 8'h77, 1, 40,   8'h88, 1, 1, 40,  8'h88, 0, 1, 0, 8'h00};
        tbl[6]  = '{0, 0,    1, 30, 8'h77, 1, 40,   8'h88, 1, 1, 30,  8'h77, 1, 0, 0, 8'h00};
        tbl[7]  = '{0, 0,    1, 30, 8'h77, 1, 40,   8'h88, 1, 1, 40,  8'h88, 0, 1, 0, 8'h00};
        tbl[8]  = '{1, 100,  1, 30, 8'h77, 1, 40,   8'h88, 1, 0, 100, 8'h00, 0, 0, 0, 8'h00};
        tbl[9]  = '{1, 100,  1, 30, 8'h77, 1, 40,   8'h88, 1, 0, 100, 8'h00, 0, 0, 1, 8'h41};
        tbl[10] = '{0, 0,    1, 30, 8'h77, 1, 40,   8'h88, 1, 1, 30,  8'h77, 1, 0, 1, 8'h41};
        tbl[11] = '{0, 0,    0, 0,  8'h00, 1, 4800, 8'h99, 0, 0, 0,   8'h00, 0, 1, 0, 8'h00};
        tbl[12] = '{0, 0,    0, 0,  8'h00, 0, 0,    8'h00, 0, 0, 0,   8'h00, 0, 0, 0, 8'h00};
        tbl[13] = '{0, 0,    1, 5,  8'h01, 1, 6,    8'h02, 1, 1, 5,   8'h01, 1, 0, 0, 8'h00};

        for (int k = 0; k < 14; k++) begin
            logic [63:0] act, exp;
            @(negedge px_clk);
            rd_req = tbl[k].rd; rd_addr = tbl[k].ra;
            wr0_req = tbl[k].w0; wr0_addr = tbl[k].a0; wr0_data = tbl[k].d0;
            wr1_req = tbl[k].w1; wr1_addr = tbl[k].a1; wr1_data = tbl[k].d1;
            @(posedge px_clk); #1;
            act = {ram_en, ram_we, tbl[k].en ? ram_addr : 13'd0,
                   (tbl[k].en && tbl[k].we) ? ram_wdata : 8'd0,
                   wr0_ack, wr1_ack, rd_valid, rd_data};
            exp = {tbl[k].en, tbl[k].we, tbl[k].ea, tbl[k].ed,
                   tbl[k].k0, tbl[k].k1, tbl[k].rv, tbl[k].rdat};
            chk($sformatf("vec%0d", k), act, exp);
        end

        // Display reads lock writer 0 out for as long as they continue.
        begin
            int bad;
            bad = 0;
            @(negedge px_clk);
            wr1_req = 1'b0;
            wr0_req = 1'b1; wr0_addr = 13'd50; wr0_data = 8'h12;
            rd_req = 1'b1; rd_addr = 13'd100;
            for (int i = 0; i < 10; i++) begin
                @(posedge px_clk); #1;
                if (wr0_ack || !ram_en || ram_we || ram_addr != 13'd100) bad++;
                if (i < 9) @(negedge px_clk);
            end
            chk("disp_prio_no_ack", bad, 0);
            @(negedge px_clk); rd_req = 1'b0;
            @(posedge px_clk); #1;
            chk("disp_prio_ack_after", {wr0_ack, ram_en, ram_we, ram_addr, ram_wdata},
                {1'b1, 1'b1, 1'b1, 13'd50, 8'h12});
            @(negedge px_clk); wr0_req = 1'b0;
        end

        // Clear with writer 0 held and a stray clr_start mid-clear.
        @(negedge px_clk);
        wr0_req = 1'b1; wr0_addr = 13'd7; wr0_data = 8'h33;
        do_clear(1'b0, DEPTH, "clr");
        @(posedge px_clk); #1;
        chk("clr_then_wr_ack", {wr0_ack, ram_en, ram_we, ram_addr, ram_wdata},
            {1'b1, 1'b1, 1'b1, 13'd7, 8'h33});
        @(negedge px_clk); wr0_req = 1'b0;

        // Clear with a display read on every other edge.
        do_clear(1'b1, 2 * DEPTH, "clr_rd");

        // Reset in the middle of a clear.
        begin
            int seen, stray;
            seen = 0; stray = 0;
            @(negedge px_clk); clr_start = 1'b1;
            @(negedge px_clk); clr_start = 1'b0;
            for (int i = 0; i < 3000 && !seen; i++) begin
                @(posedge px_clk); #1;
                if (ram_en && ram_we && ram_addr == 13'd2000) seen = 1;
            end
            chk("rst_mid_reached_2000", seen, 1);
            rst = 1'b1;
            #1;
            chk("rst_mid_outputs", {clr_busy, ram_en, ram_we}, 3'b000);
            @(negedge px_clk); rst = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(posedge px_clk); #1;
                if (ram_en || clr_busy) stray++;
            end
            chk("rst_mid_no_resume", stray, 0);
            @(negedge px_clk); clr_start = 1'b1;
            @(negedge px_clk); clr_start = 1'b0;
            @(posedge px_clk); #1;
            chk("rst_mid_restart_addr0", {ram_en, ram_we, ram_addr, ram_wdata, clr_busy},
                {1'b1, 1'b1, 13'd0, 8'h20, 1'b1});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/charbuf_arb.md
CHARBUF_ARB -- requirements
Module: charbuf_arb

Interface
REQ-001 SHALL have parameter DEPTH, default 4800, meaning number of character cells (80 cols x 60 rows).
REQ-002 SHALL have parameter AW, default 13, meaning character-buffer address width.
REQ-003 SHALL have parameter CLR_CHAR, default 8'h20, meaning fill code written by a clear sequence.
REQ-004 SHALL have port px_clk, input, 1, pixel clock; the only clock in the block.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous, active-high.
REQ-006 SHALL have port rd_req, input, 1, display fetch request, one cycle per fetch.
REQ-007 SHALL have port rd_addr, input, AW, display fetch address.
REQ-008 SHALL have port rd_data, output, 8, fetched character code.
REQ-009 SHALL have port rd_valid, output, 1, rd_data qualifier.
REQ-010 SHALL have ports wr0_req/wr1_req, input, 1 each, writer requests, held until acked.
REQ-011 SHALL have ports wr0_addr/wr1_addr, input, AW each, writer addresses.
REQ-012 SHALL have ports wr0_data/wr1_data, input, 8 each, writer character codes.
REQ-013 SHALL have ports wr0_ack/wr1_ack, output, 1 each, one-cycle write-accepted pulses.
REQ-014 SHALL have port clr_start, input, 1, pulse that starts a full-buffer clear.
REQ-015 SHALL have port clr_busy, output, 1, high while a clear is in progress.
REQ-016 SHALL have ports ram_en/ram_we, output, 1 each, single-port RAM enable and write enable.
REQ-017 SHALL have port ram_addr, output, AW, RAM address.
REQ-018 SHALL have port ram_wdata, output, 8, RAM write data.
REQ-019 SHALL have port ram_rdata, input, 8, RAM read data, valid one cycle after a read command.

Function
REQ-020 SHALL sample all requests at each px_clk edge N and drive a registered RAM command (ram_en, ram_we, ram_addr, ram_wdata) during cycle N+1.
REQ-021 SHALL grant by fixed priority: display read > clear > writers; at most one RAM command per cycle.
REQ-022 SHALL always serve rd_req: ram_en=1, ram_we=0, ram_addr=rd_addr in N+1, then rd_valid=1 with rd_data=ram_rdata in N+2 (fixed 2-cycle latency, back-to-back fetches every cycle).
REQ-023 SHALL use a two-state FSM, IDLE and CLEAR; clr_start while IDLE -> CLEAR, clear address counter reset to 0, clr_busy=1 from the next cycle.
REQ-024 SHALL in CLEAR, on each edge without rd_req, issue write of CLR_CHAR to the counter address, then increment the counter; a cycle with rd_req stalls the counter without skipping an address.
REQ-025 SHALL return to IDLE and drop clr_busy in the cycle after the write to address DEPTH-1 is issued; the counter never exceeds DEPTH-1.
REQ-026 SHALL ignore clr_start while in CLEAR (no restart).
REQ-027 SHALL, in IDLE and absent rd_req, grant one pending writer: round-robin, last-granted writer gets lower priority next time; after reset writer 0 has priority.
REQ-028 SHALL pulse wrX_ack in N+1 together with the corresponding RAM write (ram_we=1, wrX_addr, wrX_data as sampled at N).
REQ-029 SHALL treat a writer whose ack is high at edge N+1 as ineligible at that edge, so a held request is never written twice.
REQ-030 SHALL never ack writers while clr_busy=1 or in cycles granted to the display; pending writers wait with no loss.
REQ-031 SHALL ignore out-of-range addresses (>= DEPTH) from writers: ack issued, ram_en=0.
REQ-032 SHALL hold ram_en=0, ram_we=0 in any cycle with no grant; ram_addr/ram_wdata don't-care then.

Reset
REQ-033 SHALL on rst=1, immediately and asynchronously, force: FSM=IDLE, clear counter=0, clr_busy=0, rd_valid=0, rd_data=0, wr0_ack=wr1_ack=0, ram_en=ram_we=0, ram_addr=0, ram_wdata=0, round-robin pointer=writer 0.
REQ-034 SHALL abort a clear in progress on reset; no resumption after rst falls; addresses already written stay written.
REQ-035 SHALL accept requests on the first px_clk edge after rst deasserts.

Verification
REQ-036 Read latency: rd_req with rd_addr=100 for 3 consecutive cycles, RAM model returns 8'h41 -> ram_en=1, ram_we=0, addr=100 on cycles N+1..N+3; rd_valid=1, rd_data=8'h41 on N+2..N+4.
REQ-037 Round-robin: wr0_req and wr1_req held continuously, no rd_req -> acks alternate wr0, wr1, wr0, wr1; each writer exactly one write per request hold until it changes addr/data.
REQ-038 Display priority: wr0_req held while rd_req high for 10 cycles -> no wr0_ack during those cycles; wr0_ack on N+1 after first edge with rd_req low.
REQ-039 Clear: clr_start with no other traffic -> exactly 4800 writes of 8'h20, addresses 0..4799 in order, clr_busy high 4800 cycles; with rd_req every other cycle -> still 4800 writes, no skipped/duplicated address, ~9600 cycles busy.
REQ-040 Reset mid-clear: rst asserted at clear address 2000 -> clr_busy=0 and ram_en=0 immediately; after release, no further clear writes; new clr_start restarts from address 0.
REQ-041 Out-of-range: wr1_addr=4800, wr1_req -> wr1_ack pulsed, ram_en=0 in that cycle.
